register_file_n: RTL and testbench

Parametrised general-purpose register file for the single-cycle datapath. It generalises the 16×16 two-read/one-write file in data width and address depth, and keeps register 0 hard-wired to zero. It adds an asynchronous active-low reset that clears every register, a sequenced bulk-clear command with a busy/done handshake, parametrised debug taps, and optional write-to-read forwarding. It sits between instruction decode (read/write addresses) and the ALU/writeback mux. Taps feed the board display logic.

---
 rtl/register_file_n.sv | 106 ++++++++++
 tb/tb_register_file_n.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_n.sv
// Parametrised 2-read/1-write register file with r0 hard-wired to zero, sequenced bulk clear
// and debug taps. Define REGFILE_BYPASS_EN to forward same-cycle write data onto rd1/rd2.
module register_file_n #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned TAP0_IDX = 1,
  parameter int unsigned TAP1_IDX = 2,
  parameter int unsigned TAP2_IDX = 3,
  parameter int unsigned TAP3_IDX = (2 ** ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic              clr,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] tap0,
  output logic [DATA_W-1:0] tap1,
  output logic [DATA_W-1:0] tap2,
  output logic [DATA_W-1:0] tap3
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] Tap0Sel = ADDR_W'(TAP0_IDX);
  localparam logic [ADDR_W-1:0] Tap1Sel = ADDR_W'(TAP1_IDX);
  localparam logic [ADDR_W-1:0] Tap2Sel = ADDR_W'(TAP2_IDX);
  localparam logic [ADDR_W-1:0] Tap3Sel = ADDR_W'(TAP3_IDX);

  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              write_en;

  assign write_en = we3 && (wa3 != '0) && (state_q == StIdle);

  // State register: FSM, clear counter and storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clr) begin
          state_d = StClear;
          cnt_d   = ADDR_W'(1);
        end
      end
      StClear: begin
        // Counter parks at the last index rather than wrapping
        if (cnt_q == LastIdx) state_d = StDone;
        else                  cnt_d   = cnt_q + ADDR_W'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Storage next-state: a write in the clr edge commits, later clear steps wipe it
  always_comb begin
    regs_d = regs_q;
    if (write_en) regs_d[wa3] = wd3;
    if (state_q == StClear) regs_d[cnt_q] = '0;
    regs_d[0] = '0;
  end

  // Outputs
  always_comb begin
    busy = (state_q == StClear);
    done = (state_q == StDone);
`ifdef REGFILE_BYPASS_EN
    rd1 = (write_en && (ra1 == wa3)) ? wd3 : regs_q[ra1];
    rd2 = (write_en && (ra2 == wa3)) ? wd3 : regs_q[ra2];
`else
    rd1 = regs_q[ra1];
    rd2 = regs_q[ra2];
`endif
  end

  assign tap0 = regs_q[Tap0Sel];
  assign tap1 = regs_q[Tap1Sel];
  assign tap2 = regs_q[Tap2Sel];
  assign tap3 = regs_q[Tap3Sel];

endmodule

// File: tb/tb_register_file_n.sv
// Scoreboard bench for register_file_n at default parameters (16x16, taps r1/r2/r3/r15).
module tb_register_file_n;

  logic        clk, rst_n, we3, clr, busy, done;
  logic [3:0]  wa3, ra1, ra2;
  logic [15:0] wd3, rd1, rd2, tap0, tap1, tap2, tap3;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct {
    int          sel;
    string       tag;
    logic [15:0] val;
  } exp_t;
  exp_t sb_q[$];

  localparam int SelRd1 = 0, SelRd2 = 1, SelTap0 = 2, SelTap1 = 3, SelTap2 = 4, SelTap3 = 5;
  localparam int SelBusy = 6, SelDone = 7;

  register_file_n dut (
    .clk  (clk),
    .rst_n(rst_n),
    .we3  (we3),
    .wa3  (wa3),
    .wd3  (wd3),
    .ra1  (ra1),
    .ra2  (ra2),
    .clr  (clr),
    .rd1  (rd1),
    .rd2  (rd2),
    .busy (busy),
    .done (done),
    .tap0 (tap0),
    .tap1 (tap1),
    .tap2 (tap2),
    .tap3 (tap3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic push(input int sel, input string tag, input logic [15:0] val);
    exp_t e;
    e.sel = sel;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  function automatic logic [15:0] observe(input int sel);
    case (sel)
      SelRd1:  return rd1;
      SelRd2:  return rd2;
      SelTap0: return tap0;
      SelTap1: return tap1;
      SelTap2: return tap2;
      SelTap3: return tap3;
      SelBusy: return {15'd0, busy};
      default: return {15'd0, done};
    endcase
  endfunction

  task automatic drain();
    exp_t e;
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_eq(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [3:0] a, input logic [15:0] d);
    we3 = 1'b1;
    wa3 = a;
    wd3 = d;
    tick();
    we3 = 1'b0;
  endtask

  task automatic fill();
    for (int i = 1; i < 16; i++) write(4'(i), 16'(i * 16'h1111));
  endtask

  task automatic push_idle_zero(input string tag);
    push(SelRd1, {tag, "_rd1"}, 16'h0000);
    push(SelRd2, {tag, "_rd2"}, 16'h0000);
    push(SelTap0, {tag, "_tap0"}, 16'h0000);
    push(SelTap1, {tag, "_tap1"}, 16'h0000);
    push(SelTap2, {tag, "_tap2"}, 16'h0000);
    push(SelTap3, {tag, "_tap3"}, 16'h0000);
    push(SelBusy, {tag, "_busy"}, 16'h0000);
    push(SelDone, {tag, "_done"}, 16'h0000);
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    rst_n = 1'b0; we3 = 1'b0; clr = 1'b0;
    wa3 = '0; wd3 = '0; ra1 = 4'd3; ra2 = 4'd15;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    push_idle_zero("reset");
    drain();

    // Write then dual read
    write(4'd5, 16'hBEEF);
    write(4'd15, 16'h1234);
    ra1 = 4'd5; ra2 = 4'd15;
    push(SelRd1, "dual_rd1", 16'hBEEF);
    push(SelRd2, "dual_rd2", 16'h1234);
    push(SelTap3, "dual_tap3", 16'h1234);
    drain();

    // Taps
    write(4'd1, 16'h1111);
    write(4'd2, 16'h2222);
    write(4'd3, 16'h3333);
    push(SelTap0, "tap0", 16'h1111);
    push(SelTap1, "tap1", 16'h2222);
    push(SelTap2, "tap2", 16'h3333);
    drain();

    // Register 0 stays zero, including in the write cycle
    ra1 = 4'd0;
    we3 = 1'b1; wa3 = 4'd0; wd3 = 16'hFFFF;
    push(SelRd1, "r0_wcycle", 16'h0000);
    drain();
    tick();
    we3 = 1'b0;
    push(SelRd1, "r0_after", 16'h0000);
    drain();

    // Forwarding on both ports
    write(4'd7, 16'h0707);
    ra1 = 4'd7; ra2 = 4'd7;
    we3 = 1'b1; wa3 = 4'd7; wd3 = 16'hA5A5;
`ifdef REGFILE_BYPASS_EN
    push(SelRd1, "fwd_rd1", 16'hA5A5);
    push(SelRd2, "fwd_rd2", 16'hA5A5);
`else
    push(SelRd1, "fwd_rd1", 16'h0707);
    push(SelRd2, "fwd_rd2", 16'h0707);
`endif
    drain();
    tick();
    we3 = 1'b0;
    push(SelRd1, "fwd_after", 16'hA5A5);
    drain();

    // Bulk clear: r8 observed mid-clear, dropped write to r4, ignored re-clr
    fill();
    ra1 = 4'd8;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 15; k++) begin
      push(SelBusy, $sformatf("clr_busy%0d", k), 16'h0001);
      push(SelDone, $sformatf("clr_done%0d", k), 16'h0000);
      push(SelRd1, $sformatf("clr_r8_%0d", k), (k >= 8) ? 16'h0000 : 16'h8888);
      drain();
      if (k == 5) begin
        we3 = 1'b1; wa3 = 4'd4; wd3 = 16'hDEAD;
      end
      if (k == 3) clr = 1'b1;
      tick();
      we3 = 1'b0;
      clr = 1'b0;
    end
    push(SelBusy, "clr_end_busy", 16'h0000);
    push(SelDone, "clr_end_done", 16'h0001);
    drain();
    tick();
    push(SelDone, "clr_done_once", 16'h0000);
    push(SelBusy, "clr_idle_busy", 16'h0000);
    drain();
    for (int i = 0; i < 16; i++) begin
      ra1 = 4'(i);
      ra2 = 4'(15 - i);
      push(SelRd1, $sformatf("cleared_r%0d", i), 16'h0000);
      push(SelRd2, $sformatf("cleared_r%0d_p2", 15 - i), 16'h0000);
      drain();
    end

    // Reset mid-clear
    fill();
    ra1 = 4'd12; ra2 = 4'd9;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    push_idle_zero("midrst");
    drain();
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) done_cnt++;
    end
    check_eq("midrst_no_done", 16'(done_cnt), 16'd0);

    // Full sequence after abort, bounded wait for done
    write(4'd9, 16'h9999);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int k = 0; k < 40 && done_cnt == 0; k++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      tick();
    end
    check_eq("reclr_busy_cycles", 16'(busy_cnt), 16'd15);
    check_eq("reclr_done_seen", 16'(done_cnt), 16'd1);
    push(SelRd2, "reclr_r9", 16'h0000);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
